rom_load_sched: RTL and testbench

- Schedules ROM download traffic from the HPS ioctl stream into the single shared game ROM/RAM port, which the game core also reads.
- Arbitrates between download writes (held in a one-entry staging buffer) and core reads, and back-pressures the loader via a wait signal.
- Latches the game-mode byte, holds the core in reset for the whole load plus a settle period, and flags completion.
- Sits between hps_io and the blockade core, replacing direct dn_wr wiring.

---
 rtl/rom_load_pkg.sv | 26 ++
 rtl/rom_load_sched_if.sv | 27 ++
 rtl/rom_load_sched_arb.sv | 70 +++++++
 rtl/rom_load_sched.sv | 143 ++++++++++++++
 tb/tb_rom_load_sched.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM download scheduler.
package rom_load_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        SETTLE = 2'd3
    } ld_state_t;

    localparam int ROM_INDEX_DEF  = 0;
    localparam int MODE_INDEX_DEF = 1;

    typedef enum logic [1:0] {
        BLOCKADE = 2'd0,
        COMOTION = 2'd1,
        HUSTLE   = 2'd2,
        BLASTO   = 2'd3
    } game_mode_t;

    // Wrapping 16-bit accumulate of one ROM byte.
    function automatic logic [15:0] cksum_add(input logic [15:0] sum, input logic [7:0] b);
        return sum + {8'h00, b};
    endfunction

endpackage

// File: rtl/rom_load_sched_if.sv
// Download, core-read and shared-memory signals between hps_io/core and the scheduler.
interface rom_load_sched_if #(
    parameter int ADDR_W = 14
);
    logic              dl_active;
    logic [7:0]        dl_index;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              dl_wait;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_din;

    modport master (
        output dl_active, dl_index, dl_wr, dl_addr, dl_data, rd_req, rd_addr,
        input  dl_wait, rd_ack, mem_addr, mem_we, mem_din
    );

    modport slave (
        input  dl_active, dl_index, dl_wr, dl_addr, dl_data, rd_req, rd_addr,
        output dl_wait, rd_ack, mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/rom_load_sched_arb.sv
// rom_port_arb: one-entry download staging buffer and write/read grant for the shared port.
module rom_port_arb #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              pend,
    output logic              rd_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din
);
    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic [SW-1:0]     starve;
    logic              wr_win;
    logic              rd_win;

    // Grant decision: a starved write is forced through even against a read.
    always_comb begin
        wr_win   = pend && (!rd_req || (starve == STARVE_LIM));
        rd_win   = !wr_win && rd_req;
        mem_we   = wr_win;
        rd_ack   = rd_win;
        mem_addr = '0;
        mem_din  = 8'h00;
        if (wr_win) begin
            mem_addr = buf_addr;
            mem_din  = buf_data;
        end else if (rd_win) begin
            mem_addr = rd_addr;
        end else begin
            mem_addr = '0;
        end
    end

    // Buffer and starve counter; a write arriving while full is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend     <= 1'b0;
            buf_addr <= '0;
            buf_data <= 8'h00;
            starve   <= '0;
        end else begin
            if (wr_win) begin
                pend   <= 1'b0;
                starve <= '0;
            end else if (rd_win && pend && (starve != STARVE_LIM)) begin
                starve <= starve + SW'(1);
            end else begin
                starve <= starve;
            end
            if (wr_req && !pend) begin
                pend     <= 1'b1;
                buf_addr <= wr_addr;
                buf_data <= wr_data;
            end
        end
    end

endmodule

// File: rtl/rom_load_sched.sv
// rom_load_sched: ROM download scheduling, game-mode latch and core reset sequencing.
// Define ROM_LOAD_CHECKSUM_EN to add the cksum/cksum_valid outputs.
module rom_load_sched
    import rom_load_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int ROM_INDEX   = ROM_INDEX_DEF,
    parameter int MODE_INDEX  = MODE_INDEX_DEF,
    parameter int STARVE_MAX  = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    rom_load_sched_if.slave bus,
    output logic [1:0]      game_mode,
    output logic            core_reset,
    output logic            loaded
`ifdef ROM_LOAD_CHECKSUM_EN
    ,
    output logic [15:0]     cksum,
    output logic            cksum_valid
`endif
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [7:0]    ROM_IDX   = 8'(ROM_INDEX);
    localparam logic [7:0]    MODE_IDX  = 8'(MODE_INDEX);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    ld_state_t     state;
    ld_state_t     state_nx;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nx;
    logic          loaded_nx;
    logic          active_q;
    logic          rom_start;
    logic          rom_wr;

    assign rom_start = bus.dl_active && !active_q && (bus.dl_index == ROM_IDX);
    assign rom_wr    = bus.dl_wr && (bus.dl_index == ROM_IDX);

    rom_port_arb #(
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(STARVE_MAX)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .wr_req  (rom_wr),
        .wr_addr (bus.dl_addr),
        .wr_data (bus.dl_data),
        .rd_req  (bus.rd_req),
        .rd_addr (bus.rd_addr),
        .pend    (bus.dl_wait),
        .rd_ack  (bus.rd_ack),
        .mem_we  (bus.mem_we),
        .mem_addr(bus.mem_addr),
        .mem_din (bus.mem_din)
    );

    // Load sequencing; a fresh ROM download always wins over drain/settle.
    always_comb begin
        state_nx  = state;
        hold_nx   = hold;
        loaded_nx = loaded;
        case (state)
            IDLE: begin
                if (rom_start) state_nx = LOAD;
                else           state_nx = IDLE;
            end
            LOAD: begin
                if (!bus.dl_active) state_nx = DRAIN;
                else                state_nx = LOAD;
            end
            DRAIN: begin
                if (rom_start) begin
                    state_nx = LOAD;
                end else if (!bus.dl_wait) begin
                    hold_nx  = HOLD_LOAD;
                    state_nx = SETTLE;
                end else begin
                    state_nx = DRAIN;
                end
            end
            SETTLE: begin
                if (rom_start) begin
                    state_nx = LOAD;
                end else if (hold == HW'(1)) begin
                    hold_nx   = '0;
                    loaded_nx = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    hold_nx = hold - HW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sequencer registers; core_reset follows the next state so it drops with loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            loaded     <= 1'b0;
            core_reset <= 1'b1;
            active_q   <= 1'b0;
        end else begin
            state      <= state_nx;
            hold       <= hold_nx;
            loaded     <= loaded_nx;
            core_reset <= (state_nx == IDLE) ? !loaded_nx : 1'b1;
            active_q   <= bus.dl_active;
        end
    end

    // Game select latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            game_mode <= BLOCKADE;
        end else if (bus.dl_wr && (bus.dl_index == MODE_IDX)) begin
            game_mode <= bus.dl_data[1:0];
        end else begin
            game_mode <= game_mode;
        end
    end

`ifdef ROM_LOAD_CHECKSUM_EN
    // Sum of committed ROM bytes, restarted on each new load and frozen in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cksum <= 16'h0000;
        end else if ((state_nx == LOAD) && (state != LOAD)) begin
            cksum <= 16'h0000;
        end else if ((state != IDLE) && bus.mem_we) begin
            cksum <= cksum_add(cksum, bus.mem_din);
        end else begin
            cksum <= cksum;
        end
    end

    assign cksum_valid = loaded;
`endif

endmodule

// File: tb/tb_rom_load_sched.sv
// Directed + randomized bench for rom_load_sched with a RAM model and an expected-memory image.
module tb_rom_load_sched;
    import rom_load_pkg::*;

    localparam int AW    = 14;
    localparam int SMAX  = 4;
    localparam int HOLD  = 16;
    localparam int DEPTH = 1 << AW;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] game_mode;
    logic       core_reset;
    logic       loaded;
`ifdef ROM_LOAD_CHECKSUM_EN
    logic [15:0] cksum;
    logic        cksum_valid;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] mem     [DEPTH];
    logic [7:0] exp_mem [DEPTH];
    bit         exp_vld [DEPTH];

    rom_load_sched_if #(.ADDR_W(AW)) bus ();

    rom_load_sched #(
        .ADDR_W(AW), .ROM_INDEX(0), .MODE_INDEX(1), .STARVE_MAX(SMAX), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .game_mode(game_mode), .core_reset(core_reset), .loaded(loaded)
`ifdef ROM_LOAD_CHECKSUM_EN
        , .cksum(cksum), .cksum_valid(cksum_valid)
`endif
    );

    always #5 clk = ~clk;

    // Shared RAM behind the port.
    always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic send_rom(input logic [AW-1:0] a, input logic [7:0] d);
        bus.dl_wr = 1'b1; bus.dl_index = 8'd0; bus.dl_addr = a; bus.dl_data = d; bus.rd_req = 1'b0;
        mid();
        chk("wait_before_capture", 32'(bus.dl_wait), 32'd0);
        chk("no_we_on_capture", 32'(bus.mem_we), 32'd0);
        tick();
        bus.dl_wr = 1'b0;
        mid();
        chk("wait_pulse", 32'(bus.dl_wait), 32'd1);
        chk("commit_we", 32'(bus.mem_we), 32'd1);
        chk("commit_addr", 32'(bus.mem_addr), 32'(a));
        chk("commit_din", 32'(bus.mem_din), 32'(d));
        tick();
        exp_mem[a] = d; exp_vld[a] = 1'b1;
    endtask

    task automatic start_load();
        bus.dl_active = 1'b1; bus.dl_index = 8'd0;
        tick();
    endtask

    task automatic wait_release(input int max, output int n, output logic ld_prev);
        n = 0; ld_prev = loaded;
        while (core_reset === 1'b1 && n < max) begin
            ld_prev = loaded;
            tick();
            n++;
        end
    endtask

    task automatic cmp_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (exp_vld[i] && mem[i] !== exp_mem[i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int n; logic ld_prev; logic [7:0] d8; logic [AW-1:0] a, ra, wa; logic [7:0] wd, idx;
        logic rq, wr, wwin, rwin, p0, mpend; int mstarve; logic [AW-1:0] maddr; logic [7:0] mdata;
        logic [15:0] sum; int cnt;

        for (int i = 0; i < DEPTH; i++) begin exp_mem[i] = 8'h00; exp_vld[i] = 1'b0; end
        reset = 1'b1;
        bus.dl_active = 1'b0; bus.dl_index = 8'd0; bus.dl_wr = 1'b0; bus.dl_addr = '0;
        bus.dl_data = 8'h00; bus.rd_req = 1'b0; bus.rd_addr = '0;
        repeat (2) mid();
        chk("rst_dl_wait", 32'(bus.dl_wait), 32'd0);
        chk("rst_rd_ack", 32'(bus.rd_ack), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_din", 32'(bus.mem_din), 32'd0);
        chk("rst_game_mode", 32'(game_mode), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_loaded", 32'(loaded), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Mode select: fixed code 3, then a random code, then an ignored index.
        bus.dl_wr = 1'b1; bus.dl_index = 8'd1; bus.dl_data = 8'h03;
        mid(); chk("mode_no_we", 32'(bus.mem_we), 32'd0); chk("mode_not_yet", 32'(game_mode), 32'd0);
        tick(); bus.dl_wr = 1'b0;
        mid(); chk("mode_latched", 32'(game_mode), 32'd3); chk("mode_no_we2", 32'(bus.mem_we), 32'd0);
        chk("mode_no_wait", 32'(bus.dl_wait), 32'd0);
        tick();
        d8 = 8'($urandom);
        bus.dl_wr = 1'b1; bus.dl_index = 8'd1; bus.dl_data = d8;
        tick(); bus.dl_wr = 1'b0;
        mid(); chk("mode_random", 32'(game_mode), 32'(d8[1:0]));
        tick();
        bus.dl_wr = 1'b1; bus.dl_index = 8'd5; bus.dl_data = ~d8;
        tick(); bus.dl_wr = 1'b0;
        mid(); chk("ignored_mode", 32'(game_mode), 32'(d8[1:0]));
        chk("ignored_wait", 32'(bus.dl_wait), 32'd0); chk("ignored_we", 32'(bus.mem_we), 32'd0);
        tick();

        // Idle-port ROM load of 0x000..0xFFF, then completion timing.
        start_load();
        for (int i = 0; i < 4096; i++) send_rom(AW'(i), 8'($urandom));
        bus.dl_active = 1'b0;
        wait_release(100, n, ld_prev);
        // One LOAD cycle to see the fall, one DRAIN cycle, then the hold period.
        chk("release_cycles_1", 32'(n), 32'(2 + HOLD));
        chk("loaded_before_release_1", 32'(ld_prev), 32'd0);
        chk("loaded_1", 32'(loaded), 32'd1);
        chk("core_reset_1", 32'(core_reset), 32'd0);
        cmp_mem("mem_image_1");

        // Second load: starvation, dropped overlapping write, random arbitration.
        start_load();
        chk("reload_core_reset", 32'(core_reset), 32'd1);
        chk("reload_loaded", 32'(loaded), 32'd1);
        a = AW'($urandom); d8 = 8'($urandom);
        bus.dl_wr = 1'b1; bus.dl_addr = a; bus.dl_data = d8;
        tick();
        bus.dl_wr = 1'b0; bus.rd_req = 1'b1;
        for (int i = 0; i < SMAX; i++) begin
            ra = AW'($urandom); bus.rd_addr = ra;
            if (i == 1) begin bus.dl_wr = 1'b1; bus.dl_addr = ~a; bus.dl_data = ~d8; end
            else bus.dl_wr = 1'b0;
            mid();
            chk("starve_rd_ack", 32'(bus.rd_ack), 32'd1); chk("starve_no_we", 32'(bus.mem_we), 32'd0);
            chk("starve_addr", 32'(bus.mem_addr), 32'(ra)); chk("starve_wait", 32'(bus.dl_wait), 32'd1);
            tick();
        end
        bus.dl_wr = 1'b0;
        mid();
        chk("forced_we", 32'(bus.mem_we), 32'd1); chk("forced_no_ack", 32'(bus.rd_ack), 32'd0);
        chk("forced_addr", 32'(bus.mem_addr), 32'(a)); chk("forced_din", 32'(bus.mem_din), 32'(d8));
        tick();
        exp_mem[a] = d8; exp_vld[a] = 1'b1;
        mid();
        chk("after_force_ack", 32'(bus.rd_ack), 32'd1); chk("after_force_wait", 32'(bus.dl_wait), 32'd0);
        chk("after_force_we", 32'(bus.mem_we), 32'd0);
        tick();

        mpend = 1'b0; mstarve = 0; maddr = '0; mdata = 8'h00;
        for (int k = 0; k < 300; k++) begin
            rq  = ($urandom_range(3, 0) != 0);
            wr  = ($urandom_range(2, 0) == 0);
            idx = ($urandom_range(4, 0) == 0) ? 8'd7 : 8'd0;
            ra = AW'($urandom); wa = AW'($urandom); wd = 8'($urandom);
            bus.rd_req = rq; bus.rd_addr = ra; bus.dl_wr = wr; bus.dl_index = idx;
            bus.dl_addr = wa; bus.dl_data = wd;
            wwin = mpend && (!rq || mstarve == SMAX);
            rwin = !wwin && rq;
            mid();
            chk("rnd_we", 32'(bus.mem_we), 32'(wwin));
            chk("rnd_ack", 32'(bus.rd_ack), 32'(rwin));
            chk("rnd_wait", 32'(bus.dl_wait), 32'(mpend));
            chk("rnd_addr", 32'(bus.mem_addr), wwin ? 32'(maddr) : (rwin ? 32'(ra) : 32'd0));
            if (wwin) chk("rnd_din", 32'(bus.mem_din), 32'(mdata));
            p0 = mpend;
            if (wwin) begin
                exp_mem[maddr] = mdata; exp_vld[maddr] = 1'b1; mpend = 1'b0; mstarve = 0;
            end else if (rwin && mpend && mstarve < SMAX) begin
                mstarve++;
            end
            if (wr && idx == 8'd0 && !p0) begin mpend = 1'b1; maddr = wa; mdata = wd; end
            tick();
        end
        bus.dl_wr = 1'b0; bus.rd_req = 1'b0; bus.dl_index = 8'd0;
        if (mpend) begin exp_mem[maddr] = mdata; exp_vld[maddr] = 1'b1; end
        repeat (3) tick();

        // Download ends with a write still pending; it commits in DRAIN.
        a = AW'($urandom); d8 = 8'($urandom);
        bus.dl_wr = 1'b1; bus.dl_addr = a; bus.dl_data = d8;
        tick();
        bus.dl_wr = 1'b0; bus.dl_active = 1'b0; bus.rd_req = 1'b1;
        repeat (2) begin
            mid(); chk("drain_rd_wins", 32'(bus.rd_ack), 32'd1); chk("drain_pend", 32'(bus.dl_wait), 32'd1);
            tick();
        end
        bus.rd_req = 1'b0;
        mid();
        chk("drain_commit_we", 32'(bus.mem_we), 32'd1); chk("drain_commit_addr", 32'(bus.mem_addr), 32'(a));
        chk("drain_core_reset", 32'(core_reset), 32'd1);
        exp_mem[a] = d8; exp_vld[a] = 1'b1;
        wait_release(100, n, ld_prev);
        chk("release_cycles_2", 32'(n), 32'(2 + HOLD));
        chk("loaded_before_release_2", 32'(ld_prev), 32'd1);
        cmp_mem("mem_image_2");

        // 257 bytes of 0xFF; checksum is their wrapping 16-bit sum.
        start_load();
        sum = 16'h0000;
        for (int i = 0; i < 257; i++) begin
            send_rom(AW'(i), 8'hFF);
            sum = sum + 16'h00FF;
        end
        bus.dl_active = 1'b0;
        wait_release(100, n, ld_prev);
        chk("release_cycles_3", 32'(n), 32'(2 + HOLD));
`ifdef ROM_LOAD_CHECKSUM_EN
        chk("cksum", 32'(cksum), 32'(sum));
        chk("cksum_valid", 32'(cksum_valid), 32'd1);
`endif

        // New download during SETTLE returns to LOAD and keeps the core held.
        start_load();
        send_rom(AW'($urandom), 8'($urandom));
        bus.dl_active = 1'b0;
        repeat (6) tick();
        bus.dl_active = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (core_reset === 1'b1 && loaded === 1'b1) cnt++;
        end
        chk("settle_restart_hold", 32'(cnt), 32'd20);
        bus.dl_active = 1'b0;
        wait_release(100, n, ld_prev);
        chk("release_cycles_4", 32'(n), 32'(2 + HOLD));

        // Asynchronous reset with a write pending at 0x800.
        start_load();
        for (int i = 0; i < 2048; i++) send_rom(AW'(i), 8'($urandom));
        bus.dl_wr = 1'b1; bus.dl_addr = AW'(12'h800); bus.dl_data = ~exp_mem[2048];
        tick();
        bus.dl_wr = 1'b0;
        #1;
        chk("pre_reset_pend", 32'(bus.dl_wait), 32'd1);
        reset = 1'b1;
        #1;
        chk("areset_core_reset", 32'(core_reset), 32'd1);
        chk("areset_loaded", 32'(loaded), 32'd0);
        chk("areset_dl_wait", 32'(bus.dl_wait), 32'd0);
        chk("areset_mem_we", 32'(bus.mem_we), 32'd0);
        bus.dl_active = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("post_reset_we", 32'(bus.mem_we), 32'd0);
            chk("post_reset_hold", 32'({core_reset, loaded}), 32'd2);
            tick();
        end
        cmp_mem("mem_image_5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
